// File: rtl/sha1_nonce_search.sv
// Multi-lane SHA-1 nonce searcher: LANES lockstep compression datapaths, masked digest compare.
// Optional: define SHA1_NONCE_SEARCH_COUNT_EN to implement the match_count register.
module sha1_nonce_search #(
  parameter int NONCE_SIZE   = 16,
  parameter int LANES        = 4,
  parameter int NONCE_OFFSET = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  continue_on_match,
  input  logic [159:0]          context_in,
  input  logic [511:0]          block_in,
  input  logic [NONCE_SIZE-1:0] nonce_base,
  input  logic [159:0]          target,
  input  logic [159:0]          target_mask,
  output logic                  busy,
  output logic                  match,
  output logic                  done,
  output logic [NONCE_SIZE-1:0] nonce,
  output logic [511:0]          block_out,
  output logic [159:0]          context_out,
  output logic [NONCE_SIZE:0]   match_count
);

  // state    | meaning
  // S_IDLE   | waiting for start, done=0
  // S_LOAD   | build lane blocks, load a..e and W window
  // S_ROUND  | 80 compression rounds, one per cycle
  // S_FINAL  | add context, compare, advance batch counter
  // S_REPORT | one match pulse per cycle, lowest lane first
  // S_DONE   | as S_IDLE with done=1
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_FINAL, S_REPORT, S_DONE} state_t;

  localparam int LB  = $clog2(LANES);
  localparam int LIW = (LANES > 1) ? LB : 1;
  localparam logic [NONCE_SIZE:0] NB1    = (NONCE_SIZE+1)'(1);
  localparam logic [NONCE_SIZE:0] NBATCH = NB1 << (NONCE_SIZE - LB);

  state_t state, state_nx;

  logic                  cont_q;
  logic [159:0]          ctx_q, tgt_q, mask_q;
  logic [511:0]          blk_q;
  logic [NONCE_SIZE-1:0] base_q, batch_nonce, b_ofs;
  logic [NONCE_SIZE:0]   b, b_end;
  logic [6:0]            rnd;
  logic [LANES-1:0]      pend, hit, vec, rest;
  logic                  found, stop;
  logic [LIW-1:0]        first;
  logic [31:0]           kc;

  logic [31:0]           va [LANES];
  logic [31:0]           vb [LANES];
  logic [31:0]           vc [LANES];
  logic [31:0]           vd [LANES];
  logic [31:0]           ve [LANES];
  logic [31:0]           ww [LANES][16];
  logic [31:0]           tmp [LANES];
  logic [31:0]           wx [LANES];
  logic [31:0]           wnew [LANES];
  logic [159:0]          sum [LANES];
  logic [NONCE_SIZE-1:0] ld_nonce [LANES];
  logic [511:0]          ld_blk [LANES];

  logic [NONCE_SIZE-1:0] sel_nonce;
  logic [511:0]          sel_blk;
  logic [159:0]          sel_dig;

  function automatic logic [31:0] f_rnd(input logic [6:0] t, input logic [31:0] x,
                                        input logic [31:0] y, input logic [31:0] z);
    if (t < 7'd20) return (x & y) | (~x & z);
    if (t >= 7'd40 && t < 7'd60) return (x & y) | (x & z) | (y & z);
    return x ^ y ^ z;
  endfunction

  assign b_ofs = b[NONCE_SIZE-1:0] << LB;
  assign busy  = (state != S_IDLE) && (state != S_DONE);
  assign done  = (state == S_DONE);

  always_comb begin
    kc = 32'hCA62C1D6;
    if (rnd < 7'd20)      kc = 32'h5A827999;
    else if (rnd < 7'd40) kc = 32'h6ED9EBA1;
    else if (rnd < 7'd60) kc = 32'h8F1BBCDC;
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      tmp[i]  = {va[i][26:0], va[i][31:27]} + f_rnd(rnd, vb[i], vc[i], vd[i]) + ve[i] + kc + ww[i][0];
      wx[i]   = ww[i][13] ^ ww[i][8] ^ ww[i][2] ^ ww[i][0];
      wnew[i] = {wx[i][30:0], wx[i][31]};
      sum[i]  = {va[i] + ctx_q[159:128], vb[i] + ctx_q[127:96], vc[i] + ctx_q[95:64],
                 vd[i] + ctx_q[63:32], ve[i] + ctx_q[31:0]};
      hit[i]  = ((sum[i] ^ tgt_q) & mask_q) == '0;
      ld_nonce[i] = base_q + b_ofs + NONCE_SIZE'(i);
      ld_blk[i]   = blk_q;
      ld_blk[i][NONCE_OFFSET +: NONCE_SIZE] = ld_nonce[i];
    end
  end

  // FINAL reports straight from the fresh sums; REPORT reads the digests parked in a..e
  always_comb begin
    vec   = (state == S_FINAL) ? hit : pend;
    first = '0;
    for (int i = LANES - 1; i >= 0; i--)
      if (vec[i]) first = LIW'(i);
    rest      = vec & (vec - LANES'(1));
    sel_nonce = batch_nonce + NONCE_SIZE'(first);
    sel_blk   = blk_q;
    sel_blk[NONCE_OFFSET +: NONCE_SIZE] = sel_nonce;
    sel_dig   = (state == S_FINAL) ? sum[first]
                                   : {va[first], vb[first], vc[first], vd[first], ve[first]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    b_end    = (state == S_FINAL) ? b + NB1 : b;
    stop     = (b_end == NBATCH) || (!cont_q && (found || (state == S_FINAL && |hit)));
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_LOAD;
      S_LOAD:   state_nx = S_ROUND;
      S_ROUND:  if (rnd == 7'd79) state_nx = S_FINAL;
      S_FINAL:  state_nx = (|hit) ? S_REPORT : (stop ? S_DONE : S_LOAD);
      S_REPORT: state_nx = (|pend) ? S_REPORT : (stop ? S_DONE : S_LOAD);
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont_q      <= 1'b0;
      ctx_q       <= '0;
      blk_q       <= '0;
      base_q      <= '0;
      tgt_q       <= '0;
      mask_q      <= '0;
      b           <= '0;
      batch_nonce <= '0;
      rnd         <= '0;
      pend        <= '0;
      found       <= 1'b0;
      match       <= 1'b0;
      nonce       <= '0;
      block_out   <= '0;
      context_out <= '0;
    end else begin
      match <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            cont_q <= continue_on_match;
            ctx_q  <= context_in;
            blk_q  <= block_in;
            base_q <= nonce_base;
            tgt_q  <= target;
            mask_q <= target_mask;
            b      <= '0;
            pend   <= '0;
            found  <= 1'b0;
          end
        end
        S_LOAD: begin
          batch_nonce <= base_q + b_ofs;
          rnd         <= '0;
        end
        S_ROUND: rnd <= rnd + 7'd1;
        S_FINAL, S_REPORT: begin
          if (state == S_FINAL) begin
            b     <= b + NB1;
            found <= found | (|hit);
          end
          pend <= rest;
          if (|vec) begin
            match       <= 1'b1;
            nonce       <= sel_nonce;
            block_out   <= sel_blk;
            context_out <= sel_dig;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (state == S_LOAD) begin
        va[i] <= ctx_q[159:128];
        vb[i] <= ctx_q[127:96];
        vc[i] <= ctx_q[95:64];
        vd[i] <= ctx_q[63:32];
        ve[i] <= ctx_q[31:0];
        for (int j = 0; j < 16; j++) ww[i][j] <= ld_blk[i][511-32*j -: 32];
      end else if (state == S_ROUND) begin
        va[i] <= tmp[i];
        vb[i] <= va[i];
        vc[i] <= {vb[i][1:0], vb[i][31:2]};
        vd[i] <= vc[i];
        ve[i] <= vd[i];
        for (int j = 0; j < 15; j++) ww[i][j] <= ww[i][j+1];
        ww[i][15] <= wnew[i];
      end else if (state == S_FINAL) begin
        {va[i], vb[i], vc[i], vd[i], ve[i]} <= sum[i];
      end
    end
  end

`ifdef SHA1_NONCE_SEARCH_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      match_count <= '0;
    else if ((state == S_IDLE || state == S_DONE) && start)
      match_count <= '0;
    else if ((state == S_FINAL || state == S_REPORT) && |vec)
      match_count <= match_count + NB1;
  end
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_sha1_nonce_search.sv
// Bench for sha1_nonce_search: plain SHA-1 reference plus a per-cycle timeline of expected pulses.
module tb_sha1_nonce_search;
  localparam int NS  = 4;
  localparam int NL  = 4;
  localparam int OFS = 64;
  localparam logic [159:0] H_STD   = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0};
  localparam logic [159:0] ABC_DIG = {32'ha9993e36, 32'h4706816a, 32'hba3e2571, 32'h7850c26c, 32'h9cd0d89d};
  localparam logic [511:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          continue_on_match = 1'b0;
  logic [159:0]  context_in = '0;
  logic [511:0]  block_in = '0;
  logic [NS-1:0] nonce_base = '0;
  logic [159:0]  target = '0;
  logic [159:0]  target_mask = '0;
  logic          busy, match, done;
  logic [NS-1:0] nonce;
  logic [511:0]  block_out;
  logic [159:0]  context_out;
  logic [NS:0]   match_count;

  int total = 0;
  int bad   = 0;

  sha1_nonce_search #(.NONCE_SIZE(NS), .LANES(NL), .NONCE_OFFSET(OFS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continue_on_match(continue_on_match),
    .context_in(context_in), .block_in(block_in), .nonce_base(nonce_base),
    .target(target), .target_mask(target_mask), .busy(busy), .match(match), .done(done),
    .nonce(nonce), .block_out(block_out), .context_out(context_out), .match_count(match_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [NS-1:0] n;
    logic [511:0]  blk;
    logic [159:0]  dig;
  } ev_t;

  ev_t           plan_q[$];
  int            plan_done, plan_hits, plan_first;
  logic [159:0]  plan_first_dig;
  logic [NS-1:0] hold_n;
  logic [511:0]  hold_blk;
  logic [159:0]  hold_dig;
  logic          hold_valid;

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [159:0] sha1(input logic [159:0] h, input logic [511:0] m);
    logic [31:0] w[80];
    logic [31:0] a, b, c, d, e, f, k, t;
    for (int j = 0; j < 16; j++) w[j] = m[511-32*j -: 32];
    for (int j = 16; j < 80; j++) begin
      t = w[j-3] ^ w[j-8] ^ w[j-14] ^ w[j-16];
      w[j] = {t[30:0], t[31]};
    end
    {a, b, c, d, e} = h;
    for (int j = 0; j < 80; j++) begin
      if (j < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (j < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (j < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[j];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  function automatic logic [511:0] put_nonce(input logic [511:0] blk, input logic [NS-1:0] n);
    logic [511:0] r;
    r = blk;
    r[OFS +: NS] = n;
    return r;
  endfunction

  // Batch s starts (LOAD) at cycle s; its pulses follow FINAL at s+81; next batch at s+82+hits.
  task automatic make_plan(input logic [159:0] ctx, input logic [511:0] blk, input logic [NS-1:0] base,
                           input logic [159:0] tg, input logic [159:0] mk, input logic cont);
    int   s, m;
    ev_t  ev;
    plan_q.delete();
    plan_hits = 0; plan_first = -1; plan_first_dig = '0; s = 1;
    for (int bb = 0; bb < (1 << NS) / NL; bb++) begin
      m = 0;
      for (int i = 0; i < NL; i++) begin
        ev.n   = NS'((int'(base) + bb * NL + i) % (1 << NS));
        ev.blk = put_nonce(blk, ev.n);
        ev.dig = sha1(ctx, ev.blk);
        if (((ev.dig ^ tg) & mk) == '0) begin
          ev.cyc = s + 82 + m;
          if (plan_first < 0) begin plan_first = ev.cyc; plan_first_dig = ev.dig; end
          plan_q.push_back(ev);
          m++;
        end
      end
      plan_hits += m;
      plan_done = s + 82 + m;
      if (!cont && plan_hits > 0) break;
      s = s + 82 + m;
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_match"}, match, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_nonce"}, nonce, 0);
    chk({nm, "_blk"}, block_out, 0);
    chk({nm, "_ctx"}, context_out, 0);
    chk({nm, "_cnt"}, match_count, 0);
  endtask

  task automatic run_search(input logic [159:0] ctx, input logic [511:0] blk, input logic [NS-1:0] base,
                            input logic [159:0] tg, input logic [159:0] mk, input logic cont,
                            input int abort_at, input string nm);
    int   cnt, exp_cnt;
    logic exp_m, chk_hold;
    make_plan(ctx, blk, base, tg, mk, cont);
    cnt = 0;
    chk_hold = !hold_valid;
    @(negedge clk);
    context_in = ctx; block_in = blk; nonce_base = base;
    target = tg; target_mask = mk; continue_on_match = cont; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= plan_done; k++) begin
      @(negedge clk);
      if (k == abort_at) begin
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_zero({nm, "_abort"});
        hold_valid = 1'b0; hold_n = '0; hold_blk = '0; hold_dig = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk_zero({nm, "_post"});
        end
        return;
      end
      exp_m = (plan_q.size() > 0) && (plan_q[0].cyc == k);
      chk({nm, "_match"}, match, exp_m);
      chk({nm, "_busy"}, busy, k < plan_done);
      chk({nm, "_done"}, done, k == plan_done);
      if (exp_m) begin
        hold_n = plan_q[0].n; hold_blk = plan_q[0].blk; hold_dig = plan_q[0].dig;
        void'(plan_q.pop_front());
        hold_valid = 1'b1; chk_hold = 1'b1; cnt++;
      end
      if (chk_hold) begin
        chk({nm, "_nonce"}, nonce, hold_n);
        chk({nm, "_blk"}, block_out, hold_blk);
        chk({nm, "_ctx"}, context_out, hold_dig);
      end
`ifdef SHA1_NONCE_SEARCH_COUNT_EN
      exp_cnt = cnt;
`else
      exp_cnt = 0;
`endif
      chk({nm, "_cnt"}, match_count, exp_cnt);
      if (k < plan_done) begin
        start = 1'($urandom_range(0, 1));
        nonce_base = NS'($urandom);
        target = {$urandom, $urandom, $urandom, $urandom, $urandom};
        target_mask = {$urandom, $urandom, $urandom, $urandom, $urandom};
        continue_on_match = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
    end
    chk({nm, "_leftover"}, plan_q.size(), 0);
    @(negedge clk);
    chk({nm, "_idle_done"}, done, 1);
    chk({nm, "_idle_busy"}, busy, 0);
    chk({nm, "_idle_match"}, match, 0);
  endtask

  initial begin
    logic [159:0] rctx, rtg, rmk;
    logic [511:0] rblk;
    hold_valid = 1'b0; hold_n = '0; hold_blk = '0; hold_dig = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    chk("model_abc", sha1(H_STD, ABC_BLK), ABC_DIG);

    run_search(H_STD, ABC_BLK, 4'd14, '0, '1, 1'b0, 0, "unreach");
    chk("unreach_done_cyc", plan_done, 329);
    chk("unreach_hits", plan_hits, 0);

    run_search(H_STD, ABC_BLK, 4'd0, ABC_DIG, '1, 1'b0, 0, "exact");
    chk("exact_first_cyc", plan_first, 83);
    chk("exact_first_dig", plan_first_dig, ABC_DIG);
    chk("exact_done_cyc", plan_done, 84);
    chk("exact_hits", plan_hits, 1);

    run_search(H_STD, ABC_BLK, 4'd0, '0, '0, 1'b1, 0, "sweep");
    chk("sweep_done_cyc", plan_done, 345);
    chk("sweep_hits", plan_hits, 16);

    run_search(H_STD, ABC_BLK, 4'd0, '0, '0, 1'b0, 0, "first4");
    chk("first4_done_cyc", plan_done, 87);
    chk("first4_hits", plan_hits, 4);

    run_search(H_STD, ABC_BLK, 4'd0, ABC_DIG, '1, 1'b0, 40, "abort");
    run_search(H_STD, ABC_BLK, 4'd0, ABC_DIG, '1, 1'b0, 0, "fresh");

    for (int r = 0; r < 6; r++) begin
      rctx = {$urandom, $urandom, $urandom, $urandom, $urandom};
      rblk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rtg  = {$urandom, $urandom, $urandom, $urandom, $urandom};
      rmk  = '0;
      rmk[$urandom_range(0, 159)] = 1'b1;
      rmk[$urandom_range(0, 159)] = 1'b1;
      run_search(rctx, rblk, NS'($urandom), rtg, rmk, 1'($urandom_range(0, 1)), 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
